axil_reg_port_bridge: RTL
=========================

Name: axil_reg_port_bridge

Overview:
AXI4-Lite slave front end that converts single AXI-Lite read/write transactions into one-cycle register-port strobes (word address, data, byte enables, we/oe). It sits directly upstream of each accelerator wrapper's register bank and returns read data after a fixed register-bank latency. It handles one transaction at a time, with read/write arbitration and optional address-range error responses.

Parameters:
ADDR_WIDTH, 12, AXI-Lite byte address width; register-port word address is ADDR_WIDTH-2 bits.
DATA_WIDTH, 32, data width; strobe width DATA_WIDTH/8.
NUM_REGS, 32, number of implemented word registers; used only by the optional decode check.
READ_LATENCY, 1, cycles from reg_oe to valid reg_rdata (1..4).

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high reset
axil_aw_valid/axil_aw_ready  in/out  1  write-address handshake
axil_aw_addr  in  ADDR_WIDTH  write byte address
axil_w_valid/axil_w_ready  in/out  1  write-data handshake
axil_w_data  in  DATA_WIDTH  write data
axil_w_strb  in  DATA_WIDTH/8  byte strobes
axil_b_valid/axil_b_ready  out/in  1  write-response handshake
axil_b_resp  out  2  write response
axil_ar_valid/axil_ar_ready  in/out  1  read-address handshake
axil_ar_addr  in  ADDR_WIDTH  read byte address
axil_r_valid/axil_r_ready  out/in  1  read-data handshake
axil_r_data  out  DATA_WIDTH  read data
axil_r_resp  out  2  read response
reg_waddr  out  ADDR_WIDTH-2  write word address
reg_wdata  out  DATA_WIDTH  write data
reg_be  out  DATA_WIDTH/8  byte enables
reg_we  out  1  one-cycle write strobe
reg_raddr  out  ADDR_WIDTH-2  read word address
reg_oe  out  1  one-cycle read strobe
reg_rdata  in  DATA_WIDTH  read data, valid READ_LATENCY cycles after reg_oe

Behaviour:
- Reset (synchronous, active-high): every output is 0, FSM goes to IDLE, latches are cleared, and the arbitration bit selects write. Reset asserted mid-transaction abandons it and issues no strobe or response.
- FSM states: IDLE, W_NEED_DATA, W_NEED_ADDR, W_STROBE, W_RESP, R_STROBE, R_WAIT, R_RESP.
- In IDLE, aw_ready, w_ready and ar_ready are registered high. All readies are low in every other state, except aw_ready in W_NEED_ADDR and w_ready in W_NEED_DATA.
- Write path:
  - AW and W may be accepted in the same cycle or in either order. The address is latched on AW accept; data and strobe are latched on W accept.
  - AW only -> W_NEED_DATA. W only -> W_NEED_ADDR. Both -> W_STROBE.
  - W_STROBE: reg_we=1 for exactly one cycle with latched word address addr[ADDR_WIDTH-1:2], data and be. If strb==0, reg_we stays 0 and the response is still OKAY.
  - The next cycle is W_RESP: b_valid=1 and b_resp=OKAY. Both hold until b_ready, then return to IDLE. Minimum AW/W-accept-to-b_valid latency is 2 cycles.
- Read path:
  - On AR accept -> R_STROBE: reg_oe=1 for one cycle with the latched word address.
  - R_WAIT counts READ_LATENCY cycles, then captures reg_rdata into axil_r_data.
  - R_RESP: r_valid=1 and r_resp=OKAY. r_data/r_valid hold stable until r_ready, then return to IDLE.
- Low two address bits are ignored (no unaligned handling).
- Arbitration: if AR and (AW or W) are valid in the same IDLE cycle, a toggle bit picks the winner. It starts at write and flips after each arbitrated grant. The loser's ready is 0 that cycle.
- Never more than one outstanding transaction. reg_we and reg_oe are never high in the same cycle.
- AXI rule: b_valid and r_valid never depend combinationally on ready inputs; all outputs are registered.

Optional Feature:
AXIL_DECODE_ERR_EN:
- Defined: a word address >= NUM_REGS suppresses the reg_we/reg_oe strobe. The response is SLVERR (2'b10) and read data is 0; timing is unchanged.
- Undefined: all addresses are forwarded and always answered OKAY.

Decomposition:
- Package axil_reg_pkg holds:
  - resp constants OKAY=2'b00, SLVERR=2'b10;
  - the FSM state enum;
  - a word-address helper function.
- One natural sub-module: axil_rd_delay, a READ_LATENCY-deep valid shift register that produces the data-capture pulse.

Test Plan:
1. AW 0x008 and W 0xDEADBEEF/strb 0xF in the same cycle -> reg_we for one cycle with waddr=2, wdata=0xDEADBEEF, be=0xF; b_valid 2 cycles after accept, resp 0.
2. W 0x12345678 first, AW 0x010 three cycles later -> exactly one reg_we with waddr=4; aw_ready high while waiting, w_ready low.
3. AR 0x00C with reg_rdata=0xA5A5A5A5 at READ_LATENCY=1 -> reg_oe with raddr=3; r_valid 3 cycles after AR accept, data 0xA5A5A5A5; r_ready held low for 5 cycles -> data and valid remain stable.
4. AR and AW+W valid together twice in a row -> first grant is write, second is read; reg_we and reg_oe are never coincident.
5. Reset pulsed during W_RESP -> b_valid=0 the next cycle, all readies 0, then IDLE readies high; no extra reg_we.
6. With AXIL_DECODE_ERR_EN: write to 0x080 (word 32) -> no reg_we, b_resp=2'b10. Read 0x0FC -> no reg_oe, r_resp=2'b10, r_data=0.

Source files
------------

// File: rtl/axil_reg_pkg.sv
// axil_reg_pkg: shared response codes, FSM states and address helper for the AXI-Lite register-port bridge
// Contents:
//   OKAY / SLVERR  AXI response codes
//   state_t        bridge FSM states
//   word_of        byte address -> word address
package axil_reg_pkg;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        W_NEED_DATA,
        W_NEED_ADDR,
        W_STROBE,
        W_RESP,
        R_STROBE,
        R_WAIT,
        R_RESP
    } state_t;

    function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction
endpackage

// File: rtl/axil_reg_port_bridge_rd_delay.sv
// axil_rd_delay: READ_LATENCY-deep valid shift register that marks when register-bank read data is valid
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   start         one-cycle pulse in the read-strobe cycle
//   done          pulse READ_LATENCY cycles after start
module axil_rd_delay
    import axil_reg_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic done
);
    logic [READ_LATENCY-1:0] sr;

    always_ff @(posedge clock) begin
        if (reset)
            sr <= '0;
        else
            sr <= READ_LATENCY'({sr, start});
    end

    assign done = sr[READ_LATENCY-1];
endmodule

// File: rtl/axil_reg_port_bridge.sv
// axil_reg_port_bridge: AXI4-Lite slave converting single transactions into one-cycle register-port strobes
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   axil_aw_* / axil_w_*   write address / data channels
//   axil_b_*               write response channel
//   axil_ar_* / axil_r_*   read address / data channels
//   reg_waddr/wdata/be/we  write strobe to the register bank
//   reg_raddr/oe, reg_rdata read strobe and returned data (valid READ_LATENCY cycles after reg_oe)
// Build option: define AXIL_DECODE_ERR_EN to block strobes to word addresses >= NUM_REGS and answer SLVERR.
module axil_reg_port_bridge
    import axil_reg_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    axil_aw_valid,
    output logic                    axil_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   axil_aw_addr,
    input  logic                    axil_w_valid,
    output logic                    axil_w_ready,
    input  logic [DATA_WIDTH-1:0]   axil_w_data,
    input  logic [DATA_WIDTH/8-1:0] axil_w_strb,
    output logic                    axil_b_valid,
    input  logic                    axil_b_ready,
    output logic [1:0]              axil_b_resp,
    input  logic                    axil_ar_valid,
    output logic                    axil_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   axil_ar_addr,
    output logic                    axil_r_valid,
    input  logic                    axil_r_ready,
    output logic [DATA_WIDTH-1:0]   axil_r_data,
    output logic [1:0]              axil_r_resp,
    output logic [ADDR_WIDTH-3:0]   reg_waddr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_be,
    output logic                    reg_we,
    output logic [ADDR_WIDTH-3:0]   reg_raddr,
    output logic                    reg_oe,
    input  logic [DATA_WIDTH-1:0]   reg_rdata
);
    localparam int WA = ADDR_WIDTH - 2;
`ifdef AXIL_DECODE_ERR_EN
    localparam bit DECODE = 1'b1;
`else
    localparam bit DECODE = 1'b0;
`endif

    function automatic logic hit(input logic [WA-1:0] w);
        return !DECODE || (32'(w) < NUM_REGS);
    endfunction

    state_t         state;
    logic           arb;
    logic           aw_rdy, w_rdy, ar_rdy;
    logic           contend, wr_lose, rd_lose;
    logic           aw_hs, w_hs, ar_hs, rd_done;
    logic [WA-1:0]  aw_word, ar_word;

    // Readies are registered; only the arbitration loser is masked in the contended IDLE cycle.
    assign contend       = ar_rdy && (aw_rdy || w_rdy) && axil_ar_valid && (axil_aw_valid || axil_w_valid);
    assign wr_lose       = contend && arb;
    assign rd_lose       = contend && !arb;
    assign axil_aw_ready = aw_rdy && !wr_lose;
    assign axil_w_ready  = w_rdy && !wr_lose;
    assign axil_ar_ready = ar_rdy && !rd_lose;
    assign aw_hs         = axil_aw_valid && axil_aw_ready;
    assign w_hs          = axil_w_valid && axil_w_ready;
    assign ar_hs         = axil_ar_valid && axil_ar_ready;
    assign aw_word       = WA'(word_of(32'(axil_aw_addr)));
    assign ar_word       = WA'(word_of(32'(axil_ar_addr)));

    axil_rd_delay #(.READ_LATENCY(READ_LATENCY)) u_rd_delay (
        .clock (clock),
        .reset (reset),
        .start (state == R_STROBE),
        .done  (rd_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            arb                     <= 1'b0;
            {aw_rdy, w_rdy, ar_rdy} <= 3'b000;
            axil_b_valid            <= 1'b0;
            axil_b_resp             <= OKAY;
            axil_r_valid            <= 1'b0;
            axil_r_resp             <= OKAY;
            axil_r_data             <= '0;
            reg_waddr               <= '0;
            reg_wdata               <= '0;
            reg_be                  <= '0;
            reg_we                  <= 1'b0;
            reg_raddr               <= '0;
            reg_oe                  <= 1'b0;
        end else begin
            if (contend)
                arb <= !arb;
            case (state)
                IDLE: begin
                    if (aw_hs)
                        reg_waddr <= aw_word;
                    if (w_hs) begin
                        reg_wdata <= axil_w_data;
                        reg_be    <= axil_w_strb;
                    end
                    if (aw_hs && w_hs) begin
                        reg_we                  <= |axil_w_strb && hit(aw_word);
                        {aw_rdy, w_rdy, ar_rdy} <= 3'b000;
                        state                   <= W_STROBE;
                    end else if (aw_hs) begin
                        {aw_rdy, w_rdy, ar_rdy} <= 3'b010;
                        state                   <= W_NEED_DATA;
                    end else if (w_hs) begin
                        {aw_rdy, w_rdy, ar_rdy} <= 3'b100;
                        state                   <= W_NEED_ADDR;
                    end else if (ar_hs) begin
                        reg_raddr               <= ar_word;
                        reg_oe                  <= hit(ar_word);
                        {aw_rdy, w_rdy, ar_rdy} <= 3'b000;
                        state                   <= R_STROBE;
                    end else begin
                        {aw_rdy, w_rdy, ar_rdy} <= 3'b111;
                    end
                end
                W_NEED_DATA: if (w_hs) begin
                    reg_wdata <= axil_w_data;
                    reg_be    <= axil_w_strb;
                    reg_we    <= |axil_w_strb && hit(reg_waddr);
                    w_rdy     <= 1'b0;
                    state     <= W_STROBE;
                end
                W_NEED_ADDR: if (aw_hs) begin
                    reg_waddr <= aw_word;
                    reg_we    <= |reg_be && hit(aw_word);
                    aw_rdy    <= 1'b0;
                    state     <= W_STROBE;
                end
                W_STROBE: begin
                    reg_we       <= 1'b0;
                    axil_b_valid <= 1'b1;
                    axil_b_resp  <= hit(reg_waddr) ? OKAY : SLVERR;
                    state        <= W_RESP;
                end
                W_RESP: if (axil_b_ready) begin
                    axil_b_valid            <= 1'b0;
                    {aw_rdy, w_rdy, ar_rdy} <= 3'b111;
                    state                   <= IDLE;
                end
                R_STROBE: begin
                    reg_oe <= 1'b0;
                    state  <= R_WAIT;
                end
                R_WAIT: if (rd_done) begin
                    axil_r_data  <= hit(reg_raddr) ? reg_rdata : '0;
                    axil_r_resp  <= hit(reg_raddr) ? OKAY : SLVERR;
                    axil_r_valid <= 1'b1;
                    state        <= R_RESP;
                end
                R_RESP: if (axil_r_ready) begin
                    axil_r_valid            <= 1'b0;
                    {aw_rdy, w_rdy, ar_rdy} <= 3'b111;
                    state                   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
